// File: rtl/arb_priority_ager_if.sv
// Bus bundle between the priority ager and whatever drives it (the arbiter side
// shares req/grant; a config agent owns cfg*/ageLimit).
interface arb_priority_ager_if #(
  parameter int REQ_NUM   = 4,
  parameter int PRI_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  parameter int AGE_WIDTH = 8
);
  logic [REQ_NUM-1:0]           req;
  logic [REQ_NUM-1:0]           grant;
  logic                         cfgWe;
  logic [PRI_WIDTH-1:0]         cfgIdx;
  logic [PRI_WIDTH-1:0]         cfgPri;
  logic [AGE_WIDTH-1:0]         ageLimit;
  logic [REQ_NUM*PRI_WIDTH-1:0] priorityLevel;
  logic [REQ_NUM-1:0]           starve;

  modport master (
    output req, grant, cfgWe, cfgIdx, cfgPri, ageLimit,
    input  priorityLevel, starve
  );

  modport slave (
    input  req, grant, cfgWe, cfgIdx, cfgPri, ageLimit,
    output priorityLevel, starve
  );
endinterface

// File: rtl/arb_priority_ager.sv
// Priority-aging controller: per-requester effective level that climbs toward 0
// while a request waits, reloading to a programmable base on grant or idle.

// One requester's base/current level, wait counter and starve flag.
module arb_priority_ager_lane #(
  parameter int                   PRI_WIDTH = 2,
  parameter int                   AGE_WIDTH = 8,
  parameter logic [PRI_WIDTH-1:0] RST_PRI   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 grant,
  input  logic                 cfgWr,
  input  logic [PRI_WIDTH-1:0] cfgPri,
  input  logic [AGE_WIDTH-1:0] ageLimit,
  output logic [PRI_WIDTH-1:0] curPri,
  output logic                 starve
);
  logic [PRI_WIDTH-1:0] basePri;
  logic [AGE_WIDTH-1:0] waitCnt;

  // Base write, then reload / hold / promote of the effective level.
  // The reload reads the pre-write base, so a new base shows one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      basePri <= RST_PRI;
      curPri  <= RST_PRI;
      waitCnt <= '0;
      starve  <= 1'b0;
    end else begin
      if (cfgWr) basePri <= cfgPri;
      if (grant || !req) begin
        curPri  <= basePri;
        waitCnt <= '0;
        starve  <= 1'b0;
      end else if (ageLimit == '0) begin
        waitCnt <= '0;
      end else if (waitCnt >= ageLimit - AGE_WIDTH'(1)) begin
        // >= rather than == so a lowered limit promotes on the next wait edge
        waitCnt <= '0;
        if (curPri != '0) curPri <= curPri - PRI_WIDTH'(1);
        else              starve <= 1'b1;
      end else begin
        waitCnt <= waitCnt + AGE_WIDTH'(1);
      end
    end
  end
endmodule

module arb_priority_ager #(
  parameter int REQ_NUM   = 4,
  parameter int PRI_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  parameter int AGE_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  arb_priority_ager_if.slave bus
);
  logic [REQ_NUM-1:0][PRI_WIDTH-1:0] lvl;
  logic [REQ_NUM-1:0]                stv;

  for (genvar i = 0; i < REQ_NUM; i++) begin : gLane
    // Out-of-range cfgIdx matches no lane, so such writes drop silently.
    arb_priority_ager_lane #(
      .PRI_WIDTH (PRI_WIDTH),
      .AGE_WIDTH (AGE_WIDTH),
      .RST_PRI   (PRI_WIDTH'(i))
    ) uLane (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (bus.req[i]),
      .grant    (bus.grant[i]),
      .cfgWr    (bus.cfgWe && (bus.cfgIdx == PRI_WIDTH'(i))),
      .cfgPri   (bus.cfgPri),
      .ageLimit (bus.ageLimit),
      .curPri   (lvl[i]),
      .starve   (stv[i])
    );
  end

  assign bus.priorityLevel = lvl;
  assign bus.starve        = stv;
endmodule

// File: tb/tb_arb_priority_ager.sv
// Directed + randomized bench for arb_priority_ager against a per-requester
// integer model of the aging rules.
module tb_arb_priority_ager;
  localparam int N  = 4;
  localparam int PW = 2;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_priority_ager_if #(.REQ_NUM(N), .PRI_WIDTH(PW), .AGE_WIDTH(AW)) bus();

  arb_priority_ager #(.REQ_NUM(N), .PRI_WIDTH(PW), .AGE_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nTests = 0;
  int nFail  = 0;

  int mBase[N];
  int mCur[N];
  int mCnt[N];
  int mStv[N];

  function automatic void mReset();
    for (int i = 0; i < N; i++) begin
      mBase[i] = i % (1 << PW);
      mCur[i]  = mBase[i];
      mCnt[i]  = 0;
      mStv[i]  = 0;
    end
  endfunction

  // One rising edge of the spec rules, using the inputs present at the edge.
  function automatic void mStep();
    int lim;
    lim = int'(bus.ageLimit);
    for (int i = 0; i < N; i++) begin
      if (bus.grant[i] || !bus.req[i]) begin
        mCur[i] = mBase[i];
        mCnt[i] = 0;
        mStv[i] = 0;
      end else if (lim == 0) begin
        mCnt[i] = 0;
      end else if (mCnt[i] >= lim - 1) begin
        mCnt[i] = 0;
        if (mCur[i] > 0) mCur[i] = mCur[i] - 1;
        else             mStv[i] = 1;
      end else begin
        mCnt[i] = mCnt[i] + 1;
      end
    end
    if (bus.cfgWe && int'(bus.cfgIdx) < N) mBase[int'(bus.cfgIdx)] = int'(bus.cfgPri);
  endfunction

  function automatic logic [N*PW-1:0] expLvl();
    logic [N*PW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*PW +: PW] = PW'(mCur[i]);
    return v;
  endfunction

  function automatic logic [N-1:0] expStv();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = (mStv[i] != 0);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, update the model, then compare away from the edge.
  task automatic cycle();
    @(posedge clk);
    mStep();
    #1;
    chk("model_level",  32'(bus.priorityLevel), 32'(expLvl()));
    chk("model_starve", 32'(bus.starve),        32'(expStv()));
  endtask

  initial begin
    int r;
    bus.req = '0; bus.grant = '0; bus.cfgWe = 1'b0;
    bus.cfgIdx = '0; bus.cfgPri = '0; bus.ageLimit = '0;
    mReset();

    // Reset state and idle hold
    repeat (2) @(negedge clk);
    chk("rst_level",  32'(bus.priorityLevel), 32'h00E4);
    chk("rst_starve", 32'(bus.starve), 32'h0);
    rst_n = 1'b1;
    repeat (10) cycle();
    chk("idle_level", 32'(bus.priorityLevel), 32'h00E4);

    // Aging of requester 3 while requester 0 holds grant
    bus.ageLimit = 8'd4; bus.req = 4'b1001; bus.grant = 4'b0001;
    for (int e = 1; e <= 16; e++) begin
      cycle();
      if (e == 3)  chk("age_e3",  32'(bus.priorityLevel[7:6]), 32'd3);
      if (e == 4)  chk("age_e4",  32'(bus.priorityLevel[7:6]), 32'd2);
      if (e == 8)  chk("age_e8",  32'(bus.priorityLevel[7:6]), 32'd1);
      if (e == 12) chk("age_e12", 32'(bus.priorityLevel[7:6]), 32'd0);
      if (e == 15) chk("stv_e15", 32'(bus.starve[3]), 32'd0);
      if (e == 16) chk("stv_e16", 32'(bus.starve[3]), 32'd1);
      chk("lvl0_hold", 32'(bus.priorityLevel[1:0]), 32'd0);
      chk("stv0_hold", 32'(bus.starve[0]), 32'd0);
    end

    // Grant reload and restart of aging
    bus.grant = 4'b1000;
    cycle();
    chk("reload_lvl", 32'(bus.priorityLevel[7:6]), 32'd3);
    chk("reload_stv", 32'(bus.starve[3]), 32'd0);
    bus.grant = 4'b0001;
    for (int e = 1; e <= 4; e++) begin
      cycle();
      if (e == 3) chk("reage_e3", 32'(bus.priorityLevel[7:6]), 32'd3);
      if (e == 4) chk("reage_e4", 32'(bus.priorityLevel[7:6]), 32'd2);
    end

    // Config write to idle requester 2
    bus.cfgWe = 1'b1; bus.cfgIdx = 2'd2; bus.cfgPri = 2'd0;
    cycle();
    chk("cfg_idle_n", 32'(bus.priorityLevel[5:4]), 32'd2);
    bus.cfgWe = 1'b0;
    cycle();
    chk("cfg_idle_n1", 32'(bus.priorityLevel[5:4]), 32'd0);

    // Config write to waiting requester 1 at level 0
    bus.req = '0; bus.grant = '0;
    cycle();
    bus.ageLimit = 8'd2; bus.req = 4'b0010;
    repeat (2) cycle();
    chk("cfg_wait_aged", 32'(bus.priorityLevel[3:2]), 32'd0);
    bus.cfgWe = 1'b1; bus.cfgIdx = 2'd1; bus.cfgPri = 2'd3;
    cycle();
    bus.cfgWe = 1'b0;
    for (int e = 0; e < 3; e++) begin
      cycle();
      chk("cfg_wait_keep", 32'(bus.priorityLevel[3:2]), 32'd0);
    end
    bus.grant = 4'b0010;
    cycle();
    chk("cfg_wait_reload", 32'(bus.priorityLevel[3:2]), 32'd3);
    chk("cfg_wait_stv", 32'(bus.starve[1]), 32'd0);
    bus.grant = '0;

    // Aging disabled, after a reset to restore default bases
    #3 rst_n = 1'b0;
    mReset();
    bus.ageLimit = 8'd0; bus.req = 4'b1110; bus.grant = '0;
    #2 rst_n = 1'b1;
    repeat (100) cycle();
    chk("noage_level",  32'(bus.priorityLevel), 32'h00E4);
    chk("noage_starve", 32'(bus.starve), 32'h0);

    // Limit lowered from 8 to 2 mid-count
    bus.ageLimit = 8'd8; bus.req = 4'b0100;
    repeat (5) cycle();
    chk("lower_before", 32'(bus.priorityLevel[5:4]), 32'd2);
    bus.ageLimit = 8'd2;
    cycle();
    chk("lower_after", 32'(bus.priorityLevel[5:4]), 32'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      bus.req = N'($urandom);
      r = int'($urandom_range(0, N));
      bus.grant = (r == N) ? '0 : N'(1 << r);
      if ($urandom_range(0, 15) == 0) bus.ageLimit = AW'($urandom_range(0, 5));
      bus.cfgWe  = ($urandom_range(0, 7) == 0);
      bus.cfgIdx = PW'($urandom);
      bus.cfgPri = PW'($urandom);
      cycle();
    end
    bus.cfgWe = 1'b0;

    // Asynchronous reset mid-operation with a modified base
    bus.cfgWe = 1'b1; bus.cfgIdx = 2'd0; bus.cfgPri = 2'd3;
    bus.ageLimit = 8'd2; bus.req = 4'b1111; bus.grant = '0;
    cycle();
    bus.cfgWe = 1'b0;
    repeat (4) cycle();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_level",  32'(bus.priorityLevel), 32'h00E4);
    chk("async_rst_starve", 32'(bus.starve), 32'h0);
    mReset();
    @(negedge clk);
    rst_n = 1'b1; bus.req = '0;
    cycle();
    chk("rst_base_default", 32'(bus.priorityLevel), 32'h00E4);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/arb_priority_ager.md
# arb_priority_ager

Priority-aging controller that generates the `priorityLevel` bus for the dynamic-priority arbiter (`ArbDynamicPriority`), so that low-priority requesters cannot starve. Each requester has a programmable base priority and a wait counter. While a requester is pending and not granted, its effective level is promoted one step toward 0 (the highest priority) every `ageLimit` waiting cycles. The level reloads to the base value when the requester is granted or drops its request. The block sits beside the arbiter: `req` is shared, the arbiter's registered `grant` feeds back in, and `priorityLevel` drives the arbiter.

## Interface
- `REQ_NUM`, 4, number of requesters.
- `PRI_WIDTH`, clog2(`REQ_NUM`), width of one priority level; also the width of `cfgIdx`.
- `AGE_WIDTH`, 8, width of `ageLimit` and of each wait counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  `REQ_NUM`  request vector, same as the arbiter's `req`.
- `grant`  in  `REQ_NUM`  registered one-hot (or zero) grant from the arbiter.
- `cfgWe`  in  1  base-priority write strobe.
- `cfgIdx`  in  `PRI_WIDTH`  requester index to write.
- `cfgPri`  in  `PRI_WIDTH`  new base priority.
- `ageLimit`  in  `AGE_WIDTH`  waiting cycles per one-level promotion; 0 disables aging.
- `priorityLevel`  out  `REQ_NUM*PRI_WIDTH`  effective levels, registered; requester i uses bits [`PRI_WIDTH*(i+1)-1` : `PRI_WIDTH*i`].
- `starve`  out  `REQ_NUM`  requester is at level 0 and has waited a further `ageLimit` cycles; registered.

## Operation
- State per requester i:
  - `basePri[i]` (`PRI_WIDTH` bits)
  - `curPri[i]` (`PRI_WIDTH` bits; drives `priorityLevel`)
  - `waitCnt[i]` (`AGE_WIDTH` bits)
  - `starve[i]`
- Reset values:
  - `basePri[i]` = `curPri[i]` = i mod 2^`PRI_WIDTH`.
  - `waitCnt` = 0, `starve` = 0.
  - For `REQ_NUM`=4, `priorityLevel` = 8'hE4.
- Per-requester update at each rising edge, evaluated in this order:
  1. **Granted** (`grant[i]`=1): `curPri` <= `basePri`, `waitCnt` <= 0, `starve[i]` <= 0.
  2. **Idle** (`req[i]`=0): same as granted, i.e. reload and clear.
  3. **Waiting** (`req[i]`=1, `grant[i]`=0):
     - If `ageLimit`==0: hold `curPri` and `starve`; `waitCnt` <= 0.
     - Else if `waitCnt` >= `ageLimit`-1: `waitCnt` <= 0. If `curPri` > 0, `curPri` <= `curPri`-1; otherwise `starve[i]` <= 1 (sticky until rule 1 or 2 applies).
     - Else `waitCnt` <= `waitCnt`+1.
- Saturation and wrap rules:
  - `curPri` saturates at 0 and never wraps.
  - `waitCnt` never exceeds `ageLimit`-1 after any compare. The >= compare handles `ageLimit` being lowered mid-count: the next waiting edge promotes.
- Configuration write:
  - When `cfgWe`=1, `basePri[cfgIdx]` <= `cfgPri`.
  - If `cfgIdx` >= `REQ_NUM`, the write is ignored.
  - `curPri` is not touched directly. It picks up the new base at its next reload (rule 1 or 2), so a waiting requester keeps its aged level.
- Other requesters keep aging while one requester holds the grant. This is intentional: they then win the next arbitration.
- An all-zero `grant` while requests are pending counts as a waiting cycle for every pending requester.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Promotion latency: with `ageLimit`=L and requester i waiting on every edge from edge 1 onward, `curPri` decrements at edges L, 2L, 3L, and so on. `priorityLevel` changes right after those edges.
- Starve timing: with base level b, `starve[i]` rises at edge (b+1)·L.
- Reload: in the cycle after an edge that samples `grant[i]`=1 or `req[i]`=0, `priorityLevel[i]` = `basePri[i]`.
- Config latency:
  - `cfgWe` sampled at edge N updates `basePri` at edge N.
  - An idle requester shows the new level after edge N+1.
- Asynchronous reset: asserting `rst_n`=0 at any time immediately forces the reset values above, including mid-count and mid-promotion. `basePri` returns to defaults.

## Test plan
- **Reset:** release reset with `req`=0 -> `priorityLevel`=8'hE4, `starve`=0; hold for 10 cycles -> unchanged.
- **Aging:** `ageLimit`=4, `req`=4'b1001, `grant`=4'b0001 held -> level 3 reads 2 after edge 4, 1 after 8, 0 after 12; `starve[3]`=1 after edge 16. Level 0 and `starve[0]` stay 0 throughout.
- **Grant reload:** continue the aging scenario, then pulse `grant`=4'b1000 for one edge -> `priorityLevel[7:6]`=3, `starve[3]`=0, and aging restarts (level 2 after 4 more waiting edges).
- **Config:**
  - Idle requester: `cfgWe`, `cfgIdx`=2, `cfgPri`=0 while `req[2]`=0 -> `priorityLevel[5:4]`=0 two edges after the strobe.
  - Waiting requester: the same write to requester 1 while it waits at level 0 -> no change until it is granted, then it reloads to the new base.
- **Aging disabled / limit lowered:**
  - `ageLimit`=0 with `req`=4'b1110 and `grant`=0 for 100 cycles -> `priorityLevel`=8'hE4, `starve`=0.
  - `ageLimit` lowered from 8 to 2 when `waitCnt`=5 -> promotion on the next waiting edge.
- **Reset mid-operation:** drive `rst_n` low asynchronously between edges during aging with some levels promoted -> outputs return to 8'hE4 / 0 immediately, and `basePri` reverts to defaults.
